// File: rtl/nibble_serial_compare_if.sv
// Calculator/comparator bundle for nibble_serial_compare. The sequencer takes the slave side;
// the calculator control path and the external 4-bit comparator share the master side.
interface nibble_serial_compare_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         a_lt_b;
  logic         a_gt_b;
  logic         a_eq_b;
  logic         cmp_err;

  logic [3:0]   cmp_a;
  logic [3:0]   cmp_b;
  logic         cmp_alb;
  logic         cmp_agb;
  logic         cmp_aeb;
  logic         cmp_ALB;
  logic         cmp_AGB;
  logic         cmp_AEB;

  modport slave (
    input  start, op_a, op_b, cmp_ALB, cmp_AGB, cmp_AEB,
    output busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_err,
           cmp_a, cmp_b, cmp_alb, cmp_agb, cmp_aeb
  );

  modport master (
    output start, op_a, op_b, cmp_ALB, cmp_AGB, cmp_AEB,
    input  busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_err,
           cmp_a, cmp_b, cmp_alb, cmp_agb, cmp_aeb
  );
endinterface

// File: rtl/nibble_serial_compare.sv
// Serial wide magnitude compare using one external cascadable 4-bit comparator, LSB nibble first.
// Optional macro CMP_SIGNED_EN: two's complement operands (MS nibble sign bits inverted on drive).
module nibble_serial_compare #(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_compare_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  opA_q;
  logic [W-1:0]  opB_q;
  logic [2:0]    cascade_q;
  logic          busy_q;
  logic          done_q;
  logic          lt_q;
  logic          gt_q;
  logic          eq_q;
  logic          err_q;

  logic [2:0]    cascade_d;
  logic          oneHot_d;
  logic [3:0]    nibA_d;
  logic [3:0]    nibB_d;

  assign cascade_d = {bus.cmp_ALB, bus.cmp_AGB, bus.cmp_AEB};
  assign oneHot_d  = (cascade_d == 3'b100) || (cascade_d == 3'b010) || (cascade_d == 3'b001);

  always_comb begin
    nibA_d = '0;
    nibB_d = '0;
    if (state_q == RUN) begin
      nibA_d = 4'(opA_q >> {idx_q, 2'b00});
      nibB_d = 4'(opB_q >> {idx_q, 2'b00});
`ifdef CMP_SIGNED_EN
      // Flipping both sign bits turns a signed top-nibble compare into an unsigned one.
      if (idx_q == LAST) begin
        nibA_d[3] = ~nibA_d[3];
        nibB_d[3] = ~nibB_d[3];
      end
`endif
    end
  end

  assign bus.cmp_a = nibA_d;
  assign bus.cmp_b = nibB_d;
  assign {bus.cmp_alb, bus.cmp_agb, bus.cmp_aeb} = (state_q == RUN) ? cascade_q : 3'b001;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.a_lt_b  = lt_q;
  assign bus.a_gt_b  = gt_q;
  assign bus.a_eq_b  = eq_q;
  assign bus.cmp_err = err_q;

  // The comparator triple is propagated untouched even when it is malformed; cmp_err only flags it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      cascade_q <= 3'b001;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opA_q     <= bus.op_a;
            opB_q     <= bus.op_b;
            idx_q     <= '0;
            cascade_q <= 3'b001;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          cascade_q <= cascade_d;
          idx_q     <= idx_q + 1'b1;
          if (!oneHot_d) begin
            err_q <= 1'b1;
          end
          if (idx_q == LAST) begin
            {lt_q, gt_q, eq_q} <= cascade_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
